// File: rtl/fft_pkg.sv
// Shared FFT-8 constants: widths, Q10 twiddles and the 16-bit saturator.
package fft_pkg;

  localparam int CW = 32;  // packed complex word {re, im}
  localparam int PW = 16;  // one real or imaginary part
  localparam int QF = 10;  // twiddle fractional bits
  localparam int DW = 17;  // stage-1 sum/diff part width
  localparam int TW = 12;  // signed Q10 twiddle width (holds +1024)
  localparam int AW = 30;  // full-precision product accumulator

  // Forward twiddles W^k = e^(-j*2*pi*k/8) in Q10.
  localparam logic signed [TW-1:0] W_RE [4] = '{12'sd1024, 12'sd724, 12'sd0, -12'sd724};
  localparam logic signed [TW-1:0] W_IM [4] = '{12'sd0, -12'sd724, -12'sd1024, -12'sd724};

  // Conjugate twiddle: same real part, negated imaginary part.
  function automatic logic signed [TW-1:0] conj_wr(input logic [1:0] k);
    return W_RE[k];
  endfunction

  function automatic logic signed [TW-1:0] conj_wi(input logic [1:0] k);
    return -W_IM[k];
  endfunction

  // Clamp a wide signed value into the 16-bit part range.
  function automatic logic [PW-1:0] sat16(input logic signed [AW-1:0] v);
    if (v > 30'sd32767)       return 16'h7fff;
    else if (v < -30'sd32768) return 16'h8000;
    else                      return PW'(v);
  endfunction

endpackage

// File: rtl/ifft_twiddle_mult.sv
// Combinational diff x conj(W^k): full-width complex multiply, then a single
// >>>11 that folds the /2 and the Q10 scale, then per-part saturation.
module ifft_twiddle_mult
  import fft_pkg::*;
(
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic        [PW-1:0] b_re,
  output logic        [PW-1:0] b_im
);

  logic signed [AW-1:0] dre_x, dim_x, wre_x, wim_x;
  logic signed [AW-1:0] acc_re, acc_im;

  // Sign-extend to the accumulator width so no product bit is lost.
  always_comb begin
    dre_x  = AW'(d_re);
    dim_x  = AW'(d_im);
    wre_x  = AW'(w_re);
    wim_x  = AW'(w_im);
    acc_re = dre_x * wre_x - dim_x * wim_x;
    acc_im = dre_x * wim_x + dim_x * wre_x;
    b_re   = sat16(acc_re >>> (QF + 1));
    b_im   = sat16(acc_im >>> (QF + 1));
  end

endmodule

// File: rtl/block_ifft8_stream.sv
// Streaming inverse of the last radix-2 FFT-8 stage. X0..X3 are parked in a
// 4-entry buffer; each X4..X7 pairs with its partner and flows through a
// two-register butterfly/twiddle pipeline to produce (A_k, B_k).
module block_ifft8_stream
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_a,
  output logic [CW-1:0] m_b,
  output logic [1:0]    m_idx,
  output logic          m_last
);

  logic [2:0]           cnt_q, cnt_d;
  logic [CW-1:0]        hold_q [4];
  logic [CW-1:0]        hold_d [4];
  logic                 s1_vld_q, s1_vld_d;
  logic [1:0]           s1_k_q, s1_k_d;
  logic signed [DW-1:0] s1_sr_q, s1_sr_d, s1_si_q, s1_si_d;
  logic signed [DW-1:0] s1_dr_q, s1_dr_d, s1_di_q, s1_di_d;
  logic                 m_valid_q, m_valid_d;
  logic [CW-1:0]        m_a_q, m_a_d, m_b_q, m_b_d;
  logic [1:0]           m_idx_q, m_idx_d;

  logic                 pipe_en, acc;
  logic signed [PW-1:0] xr, xi, yr, yi;
  logic [PW-1:0]        b_re, b_im;

  ifft_twiddle_mult u_tw (
    .d_re (s1_dr_q),
    .d_im (s1_di_q),
    .w_re (conj_wr(s1_k_q)),
    .w_im (conj_wi(s1_k_q)),
    .b_re (b_re),
    .b_im (b_im)
  );

  // Handshake, buffer write, and both pipeline stages' next state.
  always_comb begin
    // First half only fills the buffer, so it never waits on the output side.
    pipe_en = !m_valid_q || m_ready;
    s_ready = cnt_q[2] ? pipe_en : 1'b1;
    acc     = s_valid && s_ready;

    xr = hold_q[cnt_q[1:0]][31:16];
    xi = hold_q[cnt_q[1:0]][15:0];
    yr = s_data[31:16];
    yi = s_data[15:0];

    cnt_d  = acc ? cnt_q + 3'd1 : cnt_q;
    hold_d = hold_q;
    if (acc && !cnt_q[2]) hold_d[cnt_q[1:0]] = s_data;

    s1_vld_d  = s1_vld_q;
    s1_k_d    = s1_k_q;
    s1_sr_d   = s1_sr_q;
    s1_si_d   = s1_si_q;
    s1_dr_d   = s1_dr_q;
    s1_di_d   = s1_di_q;
    m_valid_d = m_valid_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    m_idx_d   = m_idx_q;

    if (pipe_en) begin
      s1_vld_d  = acc && cnt_q[2];
      s1_k_d    = cnt_q[1:0];
      s1_sr_d   = DW'(xr) + DW'(yr);
      s1_si_d   = DW'(xi) + DW'(yi);
      s1_dr_d   = DW'(xr) - DW'(yr);
      s1_di_d   = DW'(xi) - DW'(yi);
      m_valid_d = s1_vld_q;
      // A = sum/2 with floor; a 17-bit sum halved always fits 16 bits.
      m_a_d     = {PW'(s1_sr_q >>> 1), PW'(s1_si_q >>> 1)};
      m_b_d     = {b_re, b_im};
      m_idx_d   = s1_k_q;
    end
  end

  // State registers; reset clears the frame position and drops in-flight pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
      s1_vld_q  <= 1'b0;
      s1_k_q    <= '0;
      s1_sr_q   <= '0;
      s1_si_q   <= '0;
      s1_dr_q   <= '0;
      s1_di_q   <= '0;
      m_valid_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_idx_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      s1_vld_q  <= s1_vld_d;
      s1_k_q    <= s1_k_d;
      s1_sr_q   <= s1_sr_d;
      s1_si_q   <= s1_si_d;
      s1_dr_q   <= s1_dr_d;
      s1_di_q   <= s1_di_d;
      m_valid_q <= m_valid_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      m_idx_q   <= m_idx_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_a     = m_a_q;
  assign m_b     = m_b_q;
  assign m_idx   = m_idx_q;
  assign m_last  = m_valid_q && (m_idx_q == 2'd3);

endmodule

// File: tb/tb_block_ifft8_stream.sv
// Self-checking bench for block_ifft8_stream: randomized frames compared with
// an arithmetic model of A_k/B_k, plus directed corner frames.
module tb_block_ifft8_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_idx;
  logic        m_last;

  block_ifft8_stream dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b), .m_idx(m_idx), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  idx;
    logic        last;
  } pair_t;

  int    n_cmp = 0, n_err = 0;
  int    cyc = 0, in_cnt = 0;
  int    unstable = 0, bad_stall = 0, good_stall = 0;
  logic [31:0] txq[$];
  pair_t expq[$], gotq[$];
  int    gotc[$], accc[$];
  int    rt_ar[$], rt_ai[$], rt_br[$], rt_bi[$];
  pair_t cur, prev;
  logic  held = 1'b0;

  assign cur = {m_a, m_b, m_idx, m_last};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture transfers, watch held outputs for changes, classify input stalls.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      gotq.push_back(cur);
      gotc.push_back(cyc);
    end
    if (rst_n && held && m_valid && cur !== prev) unstable <= unstable + 1;
    held <= rst_n && m_valid && !m_ready;
    prev <= cur;
    if (rst_n && s_valid && !s_ready) begin
      if (in_cnt % 8 < 4) bad_stall  <= bad_stall + 1;
      else                good_stall <= good_stall + 1;
    end
  end

  // Reference: A = floor((Xk+Xk4)/2), B = sat(floor(conj(W^k)*(Xk-Xk4)/2)).
  function automatic pair_t model(input logic [31:0] xk, input logic [31:0] xk4, input int k);
    int cwr [4] = '{1024, 724, 0, -724};
    int cwi [4] = '{0, 724, 1024, 724};
    int xr, xi, yr, yi, ar, ai, br, bi;
    pair_t p;
    xr = int'($signed(xk[31:16]));  xi = int'($signed(xk[15:0]));
    yr = int'($signed(xk4[31:16])); yi = int'($signed(xk4[15:0]));
    ar = (xr + yr) >>> 1;
    ai = (xi + yi) >>> 1;
    br = ((xr - yr) * cwr[k] - (xi - yi) * cwi[k]) >>> 11;
    bi = ((xr - yr) * cwi[k] + (xi - yi) * cwr[k]) >>> 11;
    if (br > 32767) br = 32767; else if (br < -32768) br = -32768;
    if (bi > 32767) bi = 32767; else if (bi < -32768) bi = -32768;
    p.a = {16'(ar), 16'(ai)};
    p.b = {16'(br), 16'(bi)};
    p.idx = 2'(k);
    p.last = (k == 3);
    return p;
  endfunction

  task automatic add_frame(input logic [31:0] x [8]);
    for (int i = 0; i < 8; i++) txq.push_back(x[i]);
    for (int k = 0; k < 4; k++) expq.push_back(model(x[k], x[k+4], k));
  endtask

  task automatic send_all();
    while (txq.size() > 0) begin
      int n = 0;
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = txq[0];
      while (!ok) begin
        @(negedge clk); ok = s_ready;
        @(posedge clk); #1;
        n++;
        if (!ok && n > 200) begin
          n_cmp++; n_err++;
          $display("FAIL send_timeout: s_ready=0 for %0d cycles, want 1", n);
          s_valid = 1'b0;
          txq.delete();
          return;
        end
      end
      if (in_cnt % 8 >= 4) accc.push_back(cyc);
      in_cnt++;
      void'(txq.pop_front());
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_cmp++; if ({m_a, m_b} !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {m_a, m_b}); end
    n_cmp++; if ({m_idx, m_last} !== 3'b000) begin n_err++; $display("FAIL reset_idx_last: got %b want 000", {m_idx, m_last}); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dc();
    logic [31:0] x [8];
    int base = gotq.size(), abase = accc.size();
    for (int i = 0; i < 8; i++) x[i] = {16'd100, 16'd0};
    expq.delete();
    add_frame(x);
    send_all();
    drain();
    n_cmp++; if (gotq.size() - base !== 4) begin n_err++; $display("FAIL dc_count: got %0d want 4", gotq.size() - base); end
    for (int i = 0; i < 4 && base + i < gotq.size(); i++) begin
      n_cmp++;
      if (gotq[base+i] !== {32'h0064_0000, 32'h0, 2'(i), (i == 3)}) begin
        n_err++; $display("FAIL dc_pair%0d: got %h want %h", i, gotq[base+i], {32'h0064_0000, 32'h0, 2'(i), (i == 3)});
      end
      n_cmp++;
      if (abase + i < accc.size() && gotc[base+i] - accc[abase+i] !== 1) begin
        n_err++; $display("FAIL dc_latency%0d: got %0d cycles want 1 after X%0d edge", i, gotc[base+i] - accc[abase+i], i + 4);
      end
    end
  endtask

  task automatic test_twiddle_k1();
    logic [31:0] x [8];
    int base = gotq.size();
    for (int i = 0; i < 8; i++) x[i] = '0;
    x[1] = {16'd2048, 16'd0};
    expq.delete();
    add_frame(x);
    send_all();
    drain();
    n_cmp++; if (gotq.size() - base !== 4) begin n_err++; $display("FAIL tw_count: got %0d want 4", gotq.size() - base); end
    else begin
      n_cmp++;
      if ({gotq[base+1].a, gotq[base+1].b} !== {16'd1024, 16'd0, 16'd724, 16'd724}) begin
        n_err++; $display("FAIL tw_k1: got %h want 0400000002d402d4", {gotq[base+1].a, gotq[base+1].b});
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (gotq[base+i] !== expq[i]) begin n_err++; $display("FAIL tw_pair%0d: got %h want %h", i, gotq[base+i], expq[i]); end
      end
    end
  endtask

  task automatic test_saturation_k3();
    logic [31:0] x [8];
    int base = gotq.size();
    for (int i = 0; i < 8; i++) x[i] = '0;
    x[3] = 32'h7fff_7fff;
    x[7] = 32'h8000_8000;
    expq.delete();
    add_frame(x);
    send_all();
    drain();
    n_cmp++; if (gotq.size() - base !== 4) begin n_err++; $display("FAIL sat_count: got %0d want 4", gotq.size() - base); end
    else begin
      n_cmp++;
      if ({gotq[base+3].a, gotq[base+3].b} !== 64'hffff_ffff_8000_0000) begin
        n_err++; $display("FAIL sat_k3: got %h want ffffffff80000000", {gotq[base+3].a, gotq[base+3].b});
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (gotq[base+i] !== expq[i]) begin n_err++; $display("FAIL sat_pair%0d: got %h want %h", i, gotq[base+i], expq[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x [8];
    int base = gotq.size();
    int us0 = unstable, bs0 = bad_stall, gs0 = good_stall;
    expq.delete();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) x[i] = $urandom;
      add_frame(x);
    end
    fork
      send_all();
      begin
        repeat (9) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    n_cmp++; if (bad_stall - bs0 !== 0) begin n_err++; $display("FAIL bp_first_half_stall: got %0d stalls want 0", bad_stall - bs0); end
    n_cmp++; if (good_stall - gs0 <= 0) begin n_err++; $display("FAIL bp_second_half_stall: got %0d stalls want >0", good_stall - gs0); end
    n_cmp++; if (unstable - us0 !== 0) begin n_err++; $display("FAIL bp_held_stable: got %0d changes want 0", unstable - us0); end
    n_cmp++; if (gotq.size() - base !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", gotq.size() - base); end
    for (int i = 0; i < 8 && base + i < gotq.size(); i++) begin
      n_cmp++; if (gotq[base+i] !== expq[i]) begin n_err++; $display("FAIL bp_pair%0d: got %h want %h", i, gotq[base+i], expq[i]); end
    end
  endtask

  // Forward output stage X_k = A + W^k B, X_k+4 = A - W^k B with exact twiddles
  // rounded to integers. Recovery through Q10 twiddles sees a 0.99989 gain, the
  // forward rounding and the floor, so B comes back within 3 LSB, A exactly.
  task automatic test_round_trip();
    logic [31:0] x [8];
    int base = gotq.size();
    int ar, ai, br, bi, tr, ti, gar, gai, gbr, gbi;
    real c, s;
    expq.delete();
    rt_ar.delete(); rt_ai.delete(); rt_br.delete(); rt_bi.delete();
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) begin
        ar = int'($urandom_range(15998)) - 7999; ai = int'($urandom_range(15998)) - 7999;
        br = int'($urandom_range(15998)) - 7999; bi = int'($urandom_range(15998)) - 7999;
        c = $cos(2.0 * 3.14159265358979 * k / 8.0);
        s = $sin(2.0 * 3.14159265358979 * k / 8.0);
        tr = int'(br * c + bi * s);
        ti = int'(bi * c - br * s);
        x[k]   = {16'(ar + tr), 16'(ai + ti)};
        x[k+4] = {16'(ar - tr), 16'(ai - ti)};
        rt_ar.push_back(ar); rt_ai.push_back(ai); rt_br.push_back(br); rt_bi.push_back(bi);
      end
      add_frame(x);
    end
    send_all();
    drain();
    n_cmp++; if (gotq.size() - base !== 400) begin n_err++; $display("FAIL rt_count: got %0d want 400", gotq.size() - base); end
    for (int i = 0; i < 400 && base + i < gotq.size(); i++) begin
      n_cmp++; if (gotq[base+i] !== expq[i]) begin n_err++; $display("FAIL rt_exact%0d: got %h want %h", i, gotq[base+i], expq[i]); end
      gar = int'($signed(gotq[base+i].a[31:16])); gai = int'($signed(gotq[base+i].a[15:0]));
      gbr = int'($signed(gotq[base+i].b[31:16])); gbi = int'($signed(gotq[base+i].b[15:0]));
      n_cmp++;
      if (gar - rt_ar[i] > 1 || rt_ar[i] - gar > 1 || gai - rt_ai[i] > 1 || rt_ai[i] - gai > 1 ||
          gbr - rt_br[i] > 3 || rt_br[i] - gbr > 3 || gbi - rt_bi[i] > 3 || rt_bi[i] - gbi > 3) begin
        n_err++; $display("FAIL rt_recover%0d: got A=(%0d,%0d) B=(%0d,%0d) want A=(%0d,%0d) B=(%0d,%0d)",
                          i, gar, gai, gbr, gbi, rt_ar[i], rt_ai[i], rt_br[i], rt_bi[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] x [8];
    int base;
    for (int i = 0; i < 6; i++) txq.push_back($urandom);
    send_all();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %b want 1", m_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_valid, m_last, m_idx} !== 4'b0) begin n_err++; $display("FAIL rm_ctrl: got %b want 0000", {m_valid, m_last, m_idx}); end
    n_cmp++; if ({m_a, m_b} !== 64'h0) begin n_err++; $display("FAIL rm_data: got %h want 0", {m_a, m_b}); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rm_s_ready: got %b want 1", s_ready); end
    #2 rst_n = 1'b1;
    in_cnt = 0;
    @(posedge clk); #1;
    base = gotq.size();
    expq.delete();
    for (int i = 0; i < 8; i++) x[i] = $urandom;
    add_frame(x);
    send_all();
    drain();
    n_cmp++; if (gotq.size() - base !== 4) begin n_err++; $display("FAIL rm_count: got %0d want 4", gotq.size() - base); end
    for (int i = 0; i < 4 && base + i < gotq.size(); i++) begin
      n_cmp++; if (gotq[base+i] !== expq[i]) begin n_err++; $display("FAIL rm_pair%0d: got %h want %h", i, gotq[base+i], expq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_twiddle_k1();
    test_saturation_k3();
    test_backpressure();
    test_round_trip();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
